// File: rtl/ans_decoder_if.sv
// Stream handshakes of the ANS decoder: the nibble input stream and the
// decoded-symbol output stream.
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif

interface ans_decoder_if;
   logic [`SYM_WIDTH-1:0] in;
   logic                  in_vld;
   logic                  in_rdy;
   logic [3:0]            out_sym;
   logic                  out_vld;
   logic                  out_rdy;

   modport master (output in, in_vld, out_rdy, input in_rdy, out_sym, out_vld);
   modport slave  (input in, in_vld, out_rdy, output in_rdy, out_sym, out_vld);
endinterface

// File: rtl/ans_decoder.sv
// rANS decoder: linear search over a 16-entry frequency table, one entry per
// cycle, emits one symbol per match and pulls 4-bit nibbles to renormalise.
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif

module ans_decoder (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    tbl_we,
   input  logic [3:0]              tbl_addr,
   input  logic [`CNT_WIDTH-1:0]   tbl_cnt,
   input  logic [`STATE_WIDTH-1:0] total_count,
   input  logic [`STATE_WIDTH-1:0] init_state,
   input  logic                    init_vld,
   ans_decoder_if.slave            io,
   output logic                    done,
   output logic                    err
);
   localparam int SW = `STATE_WIDTH;
   localparam int CW = `CNT_WIDTH;
   localparam int NW = `SYM_WIDTH;

   typedef enum logic [2:0] {IDLE, SEARCH, EMIT, RENORM, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   tbl [16];
   logic [SW-1:0]   x;
   logic [SW-1:0]   slot;
   logic [SW-1:0]   cum;
   logic [3:0]      idx;

   logic [CW-1:0]   cnt_cur;
   logic [SW:0]     cum_end;
   logic            hit;
   logic [SW-1:0]   x_quot;
   logic [SW-1:0]   x_dec;
   logic [SW-1:0]   x_shift;
   logic [SW-1:0]   x_mod;
   logic [SW-1:0]   shift_mod;
   logic [SW-1:0]   init_mod;

   // Datapath: one extra bit on cum+cnt so a full-range slot cannot wrap the
   // interval test; zero-count entries have an empty interval and never hit.
   always_comb begin
      cnt_cur   = tbl[idx];
      cum_end   = {1'b0, cum} + {{(SW+1-CW){1'b0}}, cnt_cur};
      hit       = (cnt_cur != '0) && (slot >= cum) && ({1'b0, slot} < cum_end);
      x_quot    = x / total_count;
      x_dec     = SW'(SW'(cnt_cur) * x_quot) + slot - cum;
      x_shift   = {x[SW-NW-1:0], io.in};
      x_mod     = x % total_count;
      shift_mod = x_shift % total_count;
      init_mod  = init_state % total_count;
   end

   // Frequency table: writable only while the decoder is not mid-stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) tbl[i] <= '0;
      end else if (ena && tbl_we && (state == IDLE || state == DONE)) begin
         tbl[tbl_addr] <= tbl_cnt;
      end
   end

   // Control FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x          <= '0;
         slot       <= '0;
         idx        <= '0;
         cum        <= '0;
         io.out_sym <= '0;
         io.out_vld <= 1'b0;
         io.in_rdy  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else if (ena) begin
         unique case (state)
            IDLE: if (init_vld) begin
               if (total_count == '0) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  x     <= init_state;
                  slot  <= init_mod;
                  idx   <= '0;
                  cum   <= '0;
                  state <= SEARCH;
               end
            end
            SEARCH: if (hit) begin
               io.out_sym <= idx;
               io.out_vld <= 1'b1;
               x          <= x_dec;
               state      <= EMIT;
            end else if (idx == 4'd15) begin
               err   <= 1'b1;
               done  <= 1'b1;
               state <= DONE;
            end else begin
               cum <= cum_end[SW-1:0];
               idx <= idx + 4'd1;
            end
            EMIT: if (io.out_rdy) begin
               io.out_vld <= 1'b0;
               if (x < total_count) begin
                  io.in_rdy <= 1'b1;
                  state     <= RENORM;
               end else if (x == total_count) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  slot  <= x_mod;
                  idx   <= '0;
                  cum   <= '0;
                  state <= SEARCH;
               end
            end
            RENORM: if (io.in_vld) begin
               x <= x_shift;
               if (x_shift == total_count) begin
                  io.in_rdy <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (x_shift > total_count) begin
                  io.in_rdy <= 1'b0;
                  slot      <= shift_mod;
                  idx       <= '0;
                  cum       <= '0;
                  state     <= SEARCH;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ans_decoder.sv
// Randomised and directed checks of ans_decoder against a queue-based
// reference decode of the rANS rules; a monitor pops expected symbols.
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif

module tb_ans_decoder;
   localparam int SW = `STATE_WIDTH;
   localparam int CW = `CNT_WIDTH;
   localparam longint unsigned MASK = (64'd1 << SW) - 1;

   logic          clk = 0;
   logic          rst = 1;
   logic          ena = 1;
   logic          tbl_we = 0;
   logic [3:0]    tbl_addr = 0;
   logic [CW-1:0] tbl_cnt = 0;
   logic [SW-1:0] total_count = 0;
   logic [SW-1:0] init_state = 0;
   logic          init_vld = 0;
   logic          done, err;

   ans_decoder_if bus();

   ans_decoder dut (
      .clk(clk), .rst(rst), .ena(ena),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_cnt(tbl_cnt),
      .total_count(total_count), .init_state(init_state), .init_vld(init_vld),
      .io(bus.slave), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          rnd = 0;
   bit          feed = 0;
   int unsigned tcnt [16];
   int unsigned expq [$];
   int unsigned nibq [$];
   int unsigned nibs [$];

   function automatic void chk(string name, longint unsigned got, longint unsigned want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endfunction

   // Reference decode: cumulative-interval lookup, plain integer arithmetic.
   function automatic void model(input longint unsigned m, input longint unsigned init,
                                 output bit fin, output bit er, output int nused);
      longint unsigned x, slot, acc;
      longint unsigned base [16];
      int s, k;
      fin = 0; er = 0; nused = 0;
      if (m == 0) begin fin = 1; er = 1; return; end
      acc = 0;
      for (int i = 0; i < 16; i++) begin base[i] = acc; acc += tcnt[i]; end
      x = init; k = 0;
      for (int step = 0; step < 1000; step++) begin
         slot = x % m;
         s = -1;
         for (int i = 0; i < 16; i++)
            if (tcnt[i] != 0 && slot >= base[i] && slot < base[i] + tcnt[i]) s = i;
         if (s < 0) begin fin = 1; er = 1; nused = k; return; end
         expq.push_back(s);
         x = (tcnt[s] * (x / m) + slot - base[s]) & MASK;
         while (x < m && k < nibs.size()) begin
            x = ((x << 4) | nibs[k]) & MASK;
            k++;
         end
         nused = k;
         if (x < m) return;
         if (x == m) begin fin = 1; return; end
      end
   endfunction

   // Monitor: every output handshake must match the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst && bus.in_rdy && bus.out_vld) begin
         checks++; errors++;
         $display("FAIL rdy_vld_overlap got 1 want 0");
      end
      if (!rst && bus.out_vld && bus.out_rdy && ena) begin
         if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sym_unexpected got %0d want none", bus.out_sym);
         end else begin
            chk("sym", bus.out_sym, expq.pop_front());
         end
      end
   end

   task automatic cyc();
      bit take;
      @(negedge clk);
      take = bus.in_rdy && bus.in_vld && ena && !rst;
      @(posedge clk); #1;
      if (take && nibq.size() != 0) void'(nibq.pop_front());
      if (rnd) begin
         ena         = ($urandom_range(0, 3) != 0);
         bus.out_rdy = ($urandom_range(0, 2) != 0);
      end
      bus.in_vld = feed && (nibq.size() != 0);
      bus.in     = (nibq.size() != 0) ? `SYM_WIDTH'(nibq[0]) : '0;
   endtask

   task automatic do_reset();
      rst = 1; rnd = 0; feed = 0; ena = 1; bus.out_rdy = 1;
      tbl_we = 0; init_vld = 0;
      cyc();
      rst = 0;
      expq.delete(); nibq.delete();
   endtask

   task automatic load_table();
      for (int i = 0; i < 16; i++) begin
         tbl_we = 1; tbl_addr = 4'(i); tbl_cnt = CW'(tcnt[i]);
         cyc();
      end
      tbl_we = 0;
   endtask

   task automatic start(input int unsigned init);
      bit r;
      r = rnd; rnd = 0; ena = 1;
      init_state = SW'(init); init_vld = 1;
      cyc();
      init_vld = 0; rnd = r;
   endtask

   task automatic run(input int budget, output int n, output int fv,
                      output bit srdy, output bit svld);
      n = 0; fv = 0; srdy = 0; svld = 0;
      while (!done && n < budget) begin
         cyc(); n++;
         if (bus.in_rdy) srdy = 1;
         if (bus.out_vld) begin svld = 1; if (fv == 0) fv = n; end
      end
   endtask

   task automatic table31();
      foreach (tcnt[i]) tcnt[i] = 0;
      tcnt[0] = 3; tcnt[1] = 1;
      load_table();
      total_count = 4;
   endtask

   initial begin
      int n, fv, nused, m, kk;
      bit srdy, svld, fin, er;
      int unsigned a, b, c, init;
      bus.in = 0; bus.in_vld = 0; bus.out_rdy = 1;

      // Reset state
      do_reset();
      chk("rst_done", done, 0); chk("rst_err", err, 0);
      chk("rst_out_vld", bus.out_vld, 0); chk("rst_in_rdy", bus.in_rdy, 0);
      chk("rst_out_sym", bus.out_sym, 0);

      // init 5: single symbol 0, lands exactly on M
      table31();
      expq.push_back(0);
      start(5); run(100, n, fv, srdy, svld);
      chk("i5_done", done, 1); chk("i5_err", err, 0); chk("i5_no_rdy", srdy, 0);
      chk("i5_drained", expq.size(), 0);

      // init 19: match at idx 1 after two search cycles
      do_reset(); table31();
      expq.push_back(1);
      start(19); run(100, n, fv, srdy, svld);
      chk("i19_latency", fv, 2); chk("i19_done", done, 1); chk("i19_err", err, 0);
      chk("i19_drained", expq.size(), 0);

      // init 7: one renormalisation nibble
      do_reset(); table31();
      expq.push_back(1); expq.push_back(1);
      nibq.push_back(3); feed = 1;
      start(7); run(100, n, fv, srdy, svld);
      chk("i7_done", done, 1); chk("i7_err", err, 0); chk("i7_rdy_seen", srdy, 1);
      chk("i7_nib_used", nibq.size(), 0); chk("i7_drained", expq.size(), 0);

      // Back-pressure in EMIT, ena low in RENORM
      do_reset(); table31();
      expq.push_back(1); expq.push_back(1);
      bus.out_rdy = 0;
      start(7);
      for (kk = 0; kk < 40 && !bus.out_vld; kk++) cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_vld", bus.out_vld, 1); chk("hold_sym", bus.out_sym, 1);
      end
      bus.out_rdy = 1;
      for (kk = 0; kk < 40 && !bus.in_rdy; kk++) cyc();
      chk("renorm_reached", bus.in_rdy, 1);
      nibq.push_back(3); feed = 1; ena = 0; bus.in_vld = 1; bus.in = 3;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("ena_lo_rdy", bus.in_rdy, 1); chk("ena_lo_nib", nibq.size(), 1);
      end
      ena = 1;
      run(100, n, fv, srdy, svld);
      chk("bp_done", done, 1); chk("bp_nib_used", nibq.size(), 0);
      chk("bp_drained", expq.size(), 0);

      // All-zero table: 16 search cycles then error
      do_reset();
      foreach (tcnt[i]) tcnt[i] = 0;
      load_table(); total_count = 4;
      start(5); run(100, n, fv, srdy, svld);
      chk("zero_cycles", n, 16); chk("zero_err", err, 1); chk("zero_done", done, 1);
      chk("zero_no_vld", svld, 0);

      // M == 0 at init
      do_reset(); total_count = 0;
      start(5);
      chk("m0_err", err, 1); chk("m0_done", done, 1);

      // Reset mid-SEARCH, then table must read back empty
      do_reset();
      foreach (tcnt[i]) tcnt[i] = 0;
      tcnt[10] = 4; load_table(); total_count = 4;
      start(5); cyc(); cyc(); cyc();
      do_reset();
      chk("rs_vld", bus.out_vld, 0); chk("rs_rdy", bus.in_rdy, 0);
      chk("rs_done", done, 0); chk("rs_err", err, 0);
      total_count = 4;
      start(5); run(100, n, fv, srdy, svld);
      chk("rs_tbl_clr_err", err, 1); chk("rs_tbl_clr_cyc", n, 16);

      // Reset during RENORM
      do_reset(); table31();
      expq.push_back(1);
      start(7);
      for (kk = 0; kk < 40 && !bus.in_rdy; kk++) cyc();
      chk("rr_reached", bus.in_rdy, 1);
      do_reset();
      chk("rr_rdy", bus.in_rdy, 0); chk("rr_vld", bus.out_vld, 0);
      chk("rr_done", done, 0); chk("rr_sym", bus.out_sym, 0);

      // Randomised decodes with random ena / out_rdy
      for (int t = 0; t < 40; t++) begin
         do_reset();
         m = $urandom_range(8, 64);
         foreach (tcnt[i]) tcnt[i] = 0;
         a = $urandom_range(0, 15);
         b = (a + $urandom_range(1, 15)) % 16;
         c = $urandom_range(0, 15);
         tcnt[a] = 1; tcnt[b] = 1;
         for (int u = 2; u < m; u++)
            case ($urandom_range(0, 2))
               0: tcnt[a]++;
               1: tcnt[b]++;
               default: tcnt[c]++;
            endcase
         load_table(); total_count = SW'(m);
         nibs.delete();
         for (int i = 0; i < $urandom_range(0, 12); i++) nibs.push_back($urandom_range(0, 15));
         nibq = nibs;
         init = $urandom_range(0, 65535);
         model(m, init, fin, er, nused);
         feed = 1; rnd = 1;
         start(init);
         if (fin) begin
            for (kk = 0; kk < 3000 && !done; kk++) cyc();
            chk("rand_done", done, 1); chk("rand_err", err, er);
         end else begin
            for (kk = 0; kk < 3000 && !(expq.size() == 0 && nibq.size() == 0 && bus.in_rdy); kk++) cyc();
            repeat (3) cyc();
            chk("rand_starve_rdy", bus.in_rdy, 1); chk("rand_starve_done", done, 0);
         end
         chk("rand_drained", expq.size(), 0);
         chk("rand_nib_used", nibs.size() - nibq.size(), nused);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ans_decoder.md
ANS_DECODER -- requirements
Module: ans_decoder

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; clock and reset are the first two ports below.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 Port: ena  input  1  clock enable; when low, no register changes except under rst.
REQ-005 Port: tbl_we  input  1  frequency-table write strobe.
REQ-006 Port: tbl_addr  input  4  symbol index written.
REQ-007 Port: tbl_cnt  input  `CNT_WIDTH  symbol count written.
REQ-008 Port: total_count  input  `STATE_WIDTH  M, sum of all table counts, static while not IDLE/DONE.
REQ-009 Port: init_state / init_vld  input  `STATE_WIDTH / 1  final encoder state; accepted only in IDLE.
REQ-010 Port: in / in_vld / in_rdy  input / input / output  `SYM_WIDTH / 1 / 1  nibble stream, fed in reverse of encoder emission order.
REQ-011 Port: out_sym / out_vld / out_rdy  output / output / input  4 / 1 / 1  decoded symbol index.
REQ-012 Port: done / err  output  1 / 1  decode complete / table inconsistency.

Function
REQ-013 SHALL hold a 16-entry count table (`CNT_WIDTH each); write when tbl_we&&ena in IDLE or DONE, ignored otherwise.
REQ-014 SHALL implement states IDLE, SEARCH, EMIT, RENORM, DONE.
REQ-015 IDLE: init_vld&&ena -> x<=init_state, slot<=init_state % total_count, idx<=0, cum<=0, go SEARCH.
REQ-016 SEARCH: one table entry per cycle; if cum<=slot<cum+cnt[idx] -> sym<=idx, x<=cnt[idx]*(x/total_count)+slot-cum, go EMIT; else cum<=cum+cnt[idx], idx<=idx+1.
REQ-017 SEARCH: zero-count entries never match; no match at idx=15 -> err<=1, go DONE.
REQ-018 SEARCH latency = matched index +1 cycles (1..16).
REQ-019 EMIT: out_vld=1, out_sym=sym stable until out_vld&&out_rdy&&ena.
REQ-020 On EMIT handshake: x<total_count -> RENORM; x==total_count -> DONE; else slot<=x % total_count, idx<=0, cum<=0, SEARCH.
REQ-021 RENORM: in_rdy=1; on in_vld&&ena, x<=(x<<4)|in, truncated to `STATE_WIDTH.
REQ-022 After each RENORM nibble: new x<total_count stays RENORM; ==total_count -> DONE; else SEARCH with slot<=new x % total_count.
REQ-023 in_rdy SHALL be 1 only in RENORM; out_vld only in EMIT; both never high together.
REQ-024 DONE: done=1, stay until rst; init_vld ignored; nibbles not consumed.
REQ-025 Arithmetic SHALL be at `STATE_WIDTH; / and % combinational within one cycle; total_count==0 on init -> err<=1, go DONE.
REQ-026 Handshake inputs with ena low SHALL be ignored; outputs hold.

Reset
REQ-027 rst SHALL force state IDLE, x=0, idx=0, cum=0, out_sym=0, out_vld=0, in_rdy=0, done=0, err=0 on next edge, from any state including mid-SEARCH or mid-handshake.
REQ-028 Table contents SHALL be cleared to 0 by rst.

Verification
REQ-029 Table cnt0=3, cnt1=1, M=4; init 5 -> out_sym=0 once, no in_rdy, done=1, err=0.
REQ-030 Same table; init 19 -> SEARCH 2 cycles, out_sym=1, then done=1.
REQ-031 Same table; init 7 -> out_sym=1, in_rdy=1, feed nibble 3 (x=19) -> out_sym=1, done=1.
REQ-032 out_rdy held low 5 cycles in EMIT -> out_sym stable, no state change; ena low 3 cycles in RENORM with in_vld=1 -> nibble not consumed.
REQ-033 All counts 0, M=4, init 5 -> 16 SEARCH cycles, err=1, done=1, out_vld never 1.
REQ-034 rst asserted mid-SEARCH and during RENORM -> all outputs 0, IDLE, table cleared next cycle.
